// File: rtl/deconversion_if.sv
// Bus bundle for the de-skew/assembly block: skewed lane input side and
// assembled-matrix output side with a ready/valid handshake.
interface deconversion_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  logic [N*DW-1:0]   Matrix;
  logic [N-1:0]      in_valid;
  logic [N*N*DW-1:0] Vector;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
  logic              skew_err;

  modport master (
    output Matrix, in_valid, out_ready,
    input  Vector, out_valid, overflow, skew_err
  );

  modport slave (
    input  Matrix, in_valid, out_ready,
    output Vector, out_valid, overflow, skew_err
  );
endinterface

// File: rtl/deconversion.sv
// Undoes systolic skew across N lanes, then gathers N aligned rows into one
// NxN matrix that is presented on a registered valid/ready output.
module deconversion #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic         clk,
  input  logic         rst,
  deconversion_if.slave bus
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  typedef logic [N-1:0][DW-1:0] row_t;
  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

  row_t         row;
  logic [N-1:0] row_v;

  // Lane k is held back N-1-k cycles so that all elements of a row line up.
  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam int D = N - 1 - k;
    if (D == 0) begin : g_pass
      assign row[k]   = bus.Matrix[k*DW +: DW];
      assign row_v[k] = bus.in_valid[k];
    end else begin : g_dly
      logic [D-1:0][DW-1:0] dat_pipe;
      logic [D-1:0]         vld_pipe;
      always_ff @(posedge clk) begin
        if (!rst) begin
          dat_pipe <= '0;
          vld_pipe <= '0;
        end else begin
          dat_pipe[0] <= bus.Matrix[k*DW +: DW];
          vld_pipe[0] <= bus.in_valid[k];
          for (int i = 1; i < D; i++) begin
            dat_pipe[i] <= dat_pipe[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
          end
        end
      end
      assign row[k]   = dat_pipe[D-1];
      assign row_v[k] = vld_pipe[D-1];
    end
  end

  mat_t          abuf;
  mat_t          asm_mat;
  mat_t          vec_q;
  logic [RW-1:0] rcnt;
  logic          ov_q;
  logic          ovf_q;
  logic          skew_q;

  logic aligned, mixed, complete, load;

  assign aligned  = &row_v;
  assign mixed    = (|row_v) & ~aligned;
  assign complete = aligned && (rcnt == RW'(N - 1));
  assign load     = complete && (!ov_q || bus.out_ready);

  // The final row bypasses the buffer so the matrix lands one edge after it.
  always_comb begin
    asm_mat      = abuf;
    asm_mat[N-1] = row;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      abuf   <= '0;
      rcnt   <= '0;
      vec_q  <= '0;
      ov_q   <= 1'b0;
      ovf_q  <= 1'b0;
      skew_q <= 1'b0;
    end else begin
      if (aligned) begin
        abuf[rcnt] <= row;
        rcnt       <= complete ? '0 : rcnt + RW'(1);
      end
      if (mixed)
        skew_q <= 1'b1;
      if (load) begin
        vec_q <= asm_mat;
        ov_q  <= 1'b1;
      end else if (ov_q && bus.out_ready) begin
        ov_q <= 1'b0;
      end
      // A completion that cannot be loaded is dropped; the held matrix wins.
      if (complete && ov_q && !bus.out_ready)
        ovf_q <= 1'b1;
    end
  end

  assign bus.Vector    = vec_q;
  assign bus.out_valid = ov_q;
  assign bus.overflow  = ovf_q;
  assign bus.skew_err  = skew_q;
endmodule
